tm_controller: RTL and testbench
================================

TM_CONTROLLER -- requirements
Module: tm_controller

Interface
REQ-001 SHALL have parameter SYM_W, default 3, tape symbol width.
REQ-002 SHALL have parameter STATE_W, default 4, machine-state width (16 states).
REQ-003 SHALL have parameter CNT_W, default 16, step-counter width.
REQ-004 SHALL have one clock and a synchronous, active-low reset: `clock` (input, 1, rising-edge clock) and `reset_n` (input, 1, synchronous active-low reset).
REQ-005 SHALL have `start` (input, 1): run-request pulse.
REQ-006 SHALL have `start_state` (input, STATE_W): initial machine state, sampled with `start`.
REQ-007 SHALL have `abort` (input, 1): stops the run.
REQ-008 SHALL have `prog_we` (input, 1): transition-table write strobe.
REQ-009 SHALL have `prog_addr` (input, STATE_W+SYM_W): table index {state, sym}.
REQ-010 SHALL have `prog_data` (input, STATE_W+SYM_W+2): entry {halt, dir, new_sym, next_state}, MSB first.
REQ-011 SHALL have `max_steps` (input, CNT_W): step limit, used only when the macro is defined.
REQ-012 SHALL have `tape_sym` (input, SYM_W): symbol under the head.
REQ-013 SHALL have `tape_write_en` (output, 1): write `tape_new_sym` at the head.
REQ-014 SHALL have `tape_new_sym` (output, SYM_W): symbol to write.
REQ-015 SHALL have `tape_move_en` (output, 1): move the head one cell.
REQ-016 SHALL have `tape_dir` (output, 1): 1 = right (+1), 0 = left (-1).
REQ-017 SHALL have `busy` (output, 1): run in progress.
REQ-018 SHALL have `halted` (output, 1): run ended on a halt entry.
REQ-019 SHALL have `timeout` (output, 1): run ended on the step limit.
REQ-020 SHALL have `tm_state` (output, STATE_W): current machine state.
REQ-021 SHALL have `step_count` (output, CNT_W): completed moves in the current run.

Function
REQ-022 SHALL implement the FSM states IDLE, READ, WRITE, MOVE and DONE.
REQ-023 SHALL, in IDLE or DONE with `start`=1, load `tm_state` from `start_state`, clear `step_count`, `halted` and `timeout`, and enter READ on the next cycle.
REQ-024 SHALL, in READ, latch the table entry at {`tm_state`, `tape_sym`} into an entry register and go to WRITE; no tape enables are asserted in READ.
REQ-025 SHALL, in WRITE, assert `tape_write_en` for exactly one cycle with `tape_new_sym` = latched new_sym, then go to DONE if halt=1, else to MOVE.
REQ-026 SHALL, in MOVE, assert `tape_move_en` for one cycle with `tape_dir` = latched dir, update `tm_state` to next_state, increment `step_count` (saturating at all-ones), and go to READ.
REQ-027 SHALL take exactly 3 cycles per non-halting step (READ, WRITE, MOVE).
REQ-028 SHALL, on a halt entry, perform the write but not the move, and set `halted`=1 on entering DONE; `tm_state` then holds the halting state.
REQ-029 SHALL drive `busy`=1 in READ, WRITE and MOVE, and 0 in IDLE and DONE.
REQ-030 SHALL, when `abort`=1 in any state, enter IDLE next cycle with both tape enables 0 in that cycle; `abort` takes priority over `start` and over all FSM transitions.
REQ-031 SHALL accept `prog_we` only in IDLE or DONE; it is ignored while `busy`=1.
REQ-032 SHALL, when `prog_we` and `start` occur together, perform the write first, so a READ on the next cycle observes the new entry.
REQ-033 SHALL never assert `tape_write_en` and `tape_move_en` in the same cycle.
REQ-034 SHALL ignore `start` while `busy`=1.

Reset
REQ-035 SHALL, with `reset_n`=0 at a clock edge, enter IDLE and clear `tm_state`, `step_count`, `halted`, `timeout` and every table entry to 0.
REQ-036 SHALL hold `busy`, `tape_write_en` and `tape_move_en` at 0, and `tape_new_sym` and `tape_dir` at 0, during reset.
REQ-037 SHALL abandon any run in progress when reset is asserted mid-run, with no further tape enables.

Configuration
REQ-038 SHALL, with `TM_STEP_LIMIT_EN` defined, enter DONE with `timeout`=1 after a MOVE that makes `step_count` equal `max_steps` (nonzero); `max_steps`=0 means no limit.
REQ-039 SHALL, without `TM_STEP_LIMIT_EN`, ignore `max_steps`, tie `timeout` to 0, and run until halt or abort.

Structure
REQ-040 SHALL place SYM_W, STATE_W, CNT_W, the FSM state enum and the table-entry struct (halt, dir, new_sym, next_state) in shared package tm_pkg.
REQ-041 SHALL hold the table storage (one write port, one asynchronous read port) in sub-module tm_transition_table.

Verification
REQ-042 SHALL cover single halt: program {0,0} = halt, new_sym 5; start_state 0 with tape_sym 0 -> one write of 5, no move, `halted`=1, `step_count`=0.
REQ-043 SHALL cover the 2-state busy beaver on a tape model: 6 steps, then halt; tape ends with four 1s, `step_count`=6, move cycles exactly 3 cycles apart.
REQ-044 SHALL cover abort: abort in WRITE -> IDLE next cycle, no `tape_move_en`, `busy`=0.
REQ-045 SHALL cover the step limit: all-zero table, `max_steps`=10 -> `timeout`=1 after 10 left moves (macro on); never terminates without the macro.
REQ-046 SHALL cover programming while busy: a `prog_we` during a run leaves the table unchanged (readback via a later run); `prog_we` and `start` together -> the new entry is used.
REQ-047 SHALL cover reset mid-run: `reset_n`=0 during MOVE -> IDLE, outputs 0, table cleared.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared widths, FSM encoding and transition-table entry layout for the
// Turing-machine sequencer.
package tm_pkg;
  localparam int SYM_W   = 3;
  localparam int STATE_W = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_MOVE,
    ST_DONE
  } tm_fsm_t;

  // Field order matches prog_data: {halt, dir, new_sym, next_state}, MSB first.
  typedef struct packed {
    logic               halt;
    logic               dir;
    logic [SYM_W-1:0]   new_sym;
    logic [STATE_W-1:0] next_state;
  } tm_entry_t;
endpackage

// File: rtl/tm_transition_table.sv
// Transition table: one synchronous write port, one asynchronous read port,
// every entry cleared by the synchronous active-low reset.
module tm_transition_table #(
  parameter int AW = tm_pkg::STATE_W + tm_pkg::SYM_W,
  parameter int DW = tm_pkg::STATE_W + tm_pkg::SYM_W + 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/tm_controller.sv
// Turing-machine sequencer: READ/WRITE/MOVE per step against an external tape.
// Define TM_STEP_LIMIT_EN to stop a run once step_count reaches max_steps.
module tm_controller #(
  parameter int SYM_W   = tm_pkg::SYM_W,
  parameter int STATE_W = tm_pkg::STATE_W,
  parameter int CNT_W   = tm_pkg::CNT_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [STATE_W-1:0]       start_state,
  input  logic                     abort,
  input  logic                     prog_we,
  input  logic [STATE_W+SYM_W-1:0] prog_addr,
  input  logic [STATE_W+SYM_W+1:0] prog_data,
  input  logic [CNT_W-1:0]         max_steps,
  input  logic [SYM_W-1:0]         tape_sym,
  output logic                     tape_write_en,
  output logic [SYM_W-1:0]         tape_new_sym,
  output logic                     tape_move_en,
  output logic                     tape_dir,
  output logic                     busy,
  output logic                     halted,
  output logic                     timeout,
  output logic [STATE_W-1:0]       tm_state,
  output logic [CNT_W-1:0]         step_count
);
  import tm_pkg::*;

  localparam int AW = STATE_W + SYM_W;
  localparam int DW = AW + 2;

  tm_fsm_t         fsm;
  tm_entry_t       entry_q, rd_entry;
  logic [DW-1:0]   rd_data;
  logic            tbl_we;
  logic [CNT_W-1:0] cnt_inc;
  logic            limit_hit;
  logic            timeout_q;

  // Table only writable while no run is active; a write coinciding with
  // start lands before the first READ.
  assign tbl_we = prog_we && (fsm == ST_IDLE || fsm == ST_DONE);

  tm_transition_table #(.AW(AW), .DW(DW)) u_table (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (tbl_we),
    .waddr   (prog_addr),
    .wdata   (prog_data),
    .raddr   ({tm_state, tape_sym}),
    .rdata   (rd_data)
  );

  assign rd_entry = tm_entry_t'(rd_data);
  assign cnt_inc  = (step_count == {CNT_W{1'b1}}) ? step_count : step_count + 1'b1;

`ifdef TM_STEP_LIMIT_EN
  assign limit_hit = (max_steps != '0) && (cnt_inc == max_steps);
  assign timeout   = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{max_steps, timeout_q};
  assign limit_hit  = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fsm           <= ST_IDLE;
      entry_q       <= '0;
      tm_state      <= '0;
      step_count    <= '0;
      halted        <= 1'b0;
      timeout_q     <= 1'b0;
      busy          <= 1'b0;
      tape_write_en <= 1'b0;
      tape_move_en  <= 1'b0;
      tape_new_sym  <= '0;
      tape_dir      <= 1'b0;
    end else if (abort) begin
      fsm           <= ST_IDLE;
      busy          <= 1'b0;
      tape_write_en <= 1'b0;
      tape_move_en  <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            tm_state   <= start_state;
            step_count <= '0;
            halted     <= 1'b0;
            timeout_q  <= 1'b0;
            busy       <= 1'b1;
            fsm        <= ST_READ;
          end
        end
        ST_READ: begin
          entry_q       <= rd_entry;
          tape_new_sym  <= rd_entry.new_sym;
          tape_write_en <= 1'b1;
          fsm           <= ST_WRITE;
        end
        ST_WRITE: begin
          tape_write_en <= 1'b0;
          if (entry_q.halt) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            fsm    <= ST_DONE;
          end else begin
            tape_move_en <= 1'b1;
            tape_dir     <= entry_q.dir;
            fsm          <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          tape_move_en <= 1'b0;
          tm_state     <= entry_q.next_state;
          step_count   <= cnt_inc;
          if (limit_hit) begin
            timeout_q <= 1'b1;
            busy      <= 1'b0;
            fsm       <= ST_DONE;
          end else begin
            fsm <= ST_READ;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tm_controller.sv
// Directed and randomized bench for tm_controller with a tape model and an
// abstract Turing-machine reference model.
module tb_tm_controller;
  localparam int SYM_W = 3, STATE_W = 4, CNT_W = 16, AW = 7, DW = 9;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [STATE_W-1:0] start_state = '0;
  logic               abort = 1'b0;
  logic               prog_we = 1'b0;
  logic [AW-1:0]      prog_addr = '0;
  logic [DW-1:0]      prog_data = '0;
  logic [CNT_W-1:0]   max_steps = 16'd10;
  logic [SYM_W-1:0]   tape_sym;
  logic               tape_write_en, tape_move_en, tape_dir, busy, halted, timeout;
  logic [SYM_W-1:0]   tape_new_sym;
  logic [STATE_W-1:0] tm_state;
  logic [CNT_W-1:0]   step_count;

  always #5 clock = ~clock;

  tm_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_state(start_state),
    .abort(abort), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .max_steps(max_steps), .tape_sym(tape_sym), .tape_write_en(tape_write_en),
    .tape_new_sym(tape_new_sym), .tape_move_en(tape_move_en), .tape_dir(tape_dir),
    .busy(busy), .halted(halted), .timeout(timeout), .tm_state(tm_state),
    .step_count(step_count)
  );

  // Tape model: head starts mid-tape; writes/moves applied on the falling edge.
  logic [SYM_W-1:0] tape [256];
  logic [7:0]       head = 8'd128;
  logic             tape_clr = 1'b1;
  int               cyc = 0;
  int               both_cnt = 0;
  int               mv_q[$];
  int               wr_q[$];

  assign tape_sym = tape[head];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (tape_write_en && tape_move_en) both_cnt <= both_cnt + 1;
    if (tape_clr) begin
      for (int i = 0; i < 256; i++) tape[i] <= '0;
      head <= 8'd128;
    end else begin
      if (tape_write_en) begin
        tape[head] <= tape_new_sym;
        wr_q.push_back(int'(tape_new_sym));
      end
      if (tape_move_en) begin
        head <= tape_dir ? head + 8'd1 : head - 8'd1;
        mv_q.push_back(cyc);
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0]    ref_tbl [128];
  logic [SYM_W-1:0] mtape [256];

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input bit h, input bit d, input int s, input int nx);
    logic [2:0] s3 = s[2:0];
    logic [3:0] n4 = nx[3:0];
    return {h, d, s3, n4};
  endfunction

  function automatic logic [AW-1:0] ad(input int st, input int sym);
    logic [3:0] s4 = st[3:0];
    logic [2:0] y3 = sym[2:0];
    return {s4, y3};
  endfunction

  task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_addr = a; prog_data = d; prog_we = 1'b1;
    ref_tbl[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic clear_tape();
    tape_clr = 1'b1; tick(2); tape_clr = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] ss);
    start_state = ss; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk({tag, "_finished"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_sig(input bit which_move, input int budget, input string tag);
    int k = 0;
    while (!(which_move ? tape_move_en : tape_write_en) && k < budget) begin tick(); k++; end
    chk({tag, "_seen"}, {31'd0, which_move ? tape_move_en : tape_write_en}, 32'd1);
  endtask

  // Abstract machine: look up {state, symbol}, write, halt or move, repeat.
  task automatic model_run(input logic [3:0] ss, input int lim, output bit h,
                           output int steps, output logic [3:0] fs);
    int p = 128;
    logic [3:0] st = ss;
    logic [DW-1:0] e;
    for (int i = 0; i < 256; i++) mtape[i] = '0;
    h = 0; steps = 0;
    while (!h && steps < lim) begin
      e = ref_tbl[{st, mtape[p]}];
      mtape[p] = e[6:4];
      if (e[8]) h = 1;
      else begin
        p = e[7] ? (p + 1) % 256 : (p + 255) % 256;
        st = e[3:0];
        steps++;
      end
    end
    fs = st;
  endtask

  initial begin
    int w0, m0, mm, ones, gaps, tries, msteps;
    bit mh;
    logic [3:0] mfs, ss;
    for (int i = 0; i < 128; i++) ref_tbl[i] = '0;

    // reset
    tick(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wen", {31'd0, tape_write_en}, 0);
    chk("rst_men", {31'd0, tape_move_en}, 0);
    chk("rst_sym", {29'd0, tape_new_sym}, 0);
    chk("rst_dir", {31'd0, tape_dir}, 0);
    chk("rst_state", {28'd0, tm_state}, 0);
    chk("rst_cnt", {16'd0, step_count}, 0);
    chk("rst_flags", {30'd0, halted, timeout}, 0);
    reset_n = 1'b1; tape_clr = 1'b0; tick();

    // step limit on the all-zero table
    m0 = mv_q.size();
    start_run(0);
`ifdef TM_STEP_LIMIT_EN
    wait_idle(100, "limit");
    chk("limit_timeout", {31'd0, timeout}, 1);
    chk("limit_halted", {31'd0, halted}, 0);
    chk("limit_cnt", {16'd0, step_count}, 10);
    chk("limit_moves", mv_q.size() - m0, 10);
    chk("limit_head", {24'd0, head}, 118);
`else
    tick(60);
    chk("nolimit_busy", {31'd0, busy}, 1);
    chk("nolimit_timeout", {31'd0, timeout}, 0);
    chk("nolimit_cnt", {16'd0, step_count}, mv_q.size() - m0);
    abort = 1'b1; tick(); abort = 1'b0;
`endif
    max_steps = '0;

    // single halt
    prog(ad(0, 0), mk(1, 0, 5, 0));
    clear_tape(); w0 = wr_q.size(); m0 = mv_q.size();
    start_run(0);
    wait_idle(20, "halt1");
    chk("halt1_writes", wr_q.size() - w0, 1);
    chk("halt1_sym", wr_q[$], 5);
    chk("halt1_moves", mv_q.size() - m0, 0);
    chk("halt1_halted", {31'd0, halted}, 1);
    chk("halt1_cnt", {16'd0, step_count}, 0);
    chk("halt1_tape", {29'd0, tape[128]}, 5);

    // abort in WRITE on a never-halting entry
    prog(ad(4, 0), mk(0, 1, 0, 4));
    clear_tape();
    start_run(4);
    wait_sig(0, 10, "abort_write");
    m0 = mv_q.size();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_en", {30'd0, tape_write_en, tape_move_en}, 0);
    tick(4);
    chk("abort_nomove", mv_q.size() - m0, 0);

    // prog_we while busy must be dropped
    start_run(4); tick(2);
    prog_addr = ad(5, 0); prog_data = mk(1, 0, 6, 0); prog_we = 1'b1;
    tick(); prog_we = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    clear_tape();
    start_run(5);
    wait_idle(30, "busyprog");
    chk("busyprog_state", {28'd0, tm_state}, 0);
    chk("busyprog_cnt", {16'd0, step_count}, 1);
    chk("busyprog_sym", wr_q[$], 5);

    // prog_we together with start: new entry used
    clear_tape();
    prog_addr = ad(6, 0); prog_data = mk(1, 0, 3, 9); prog_we = 1'b1;
    ref_tbl[ad(6, 0)] = mk(1, 0, 3, 9);
    start_state = 4'd6; start = 1'b1;
    tick(); prog_we = 1'b0; start = 1'b0;
    wait_idle(20, "progstart");
    chk("progstart_halted", {31'd0, halted}, 1);
    chk("progstart_state", {28'd0, tm_state}, 6);
    chk("progstart_sym", wr_q[$], 3);

    // 2-state busy beaver (state 2 is the halting state)
    prog(ad(0, 0), mk(0, 1, 1, 1)); prog(ad(0, 1), mk(0, 0, 1, 1));
    prog(ad(1, 0), mk(0, 0, 1, 0)); prog(ad(1, 1), mk(0, 1, 1, 2));
    prog(ad(2, 0), mk(1, 0, 0, 2)); prog(ad(2, 1), mk(1, 0, 1, 2));
    clear_tape(); m0 = mv_q.size();
    start_run(0);
    wait_idle(60, "bb");
    ones = 0;
    for (int i = 0; i < 256; i++) if (tape[i] == 3'd1) ones++;
    gaps = 0;
    for (int i = m0 + 1; i < mv_q.size(); i++) if (mv_q[i] - mv_q[i-1] != 3) gaps++;
    chk("bb_halted", {31'd0, halted}, 1);
    chk("bb_cnt", {16'd0, step_count}, 6);
    chk("bb_ones", ones, 4);
    chk("bb_moves", mv_q.size() - m0, 6);
    chk("bb_spacing", gaps, 0);

    // random tables against the reference model
    for (int it = 0; it < 6; it++) begin
      tries = 0;
      do begin
        for (int a = 0; a < 128; a++)
          ref_tbl[a] = mk($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7), $urandom_range(0, 15));
        ss = 4'($urandom_range(0, 15));
        model_run(ss, 100, mh, msteps, mfs);
        tries++;
      end while (!mh && tries < 200);
      for (int a = 0; a < 128; a++) prog(AW'(a), ref_tbl[a]);
      clear_tape(); w0 = wr_q.size(); m0 = mv_q.size();
      start_run(ss);
      wait_idle(3 * 100 + 20, "rand");
      mm = 0;
      for (int i = 0; i < 256; i++) if (tape[i] !== mtape[i]) mm++;
      chk("rand_halted", {31'd0, halted}, {31'd0, mh});
      chk("rand_cnt", {16'd0, step_count}, msteps);
      chk("rand_state", {28'd0, tm_state}, {28'd0, mfs});
      chk("rand_moves", mv_q.size() - m0, msteps);
      chk("rand_writes", wr_q.size() - w0, msteps + 1);
      chk("rand_tape", mm, 0);
    end

    // reset during MOVE
    prog(ad(4, 0), mk(0, 1, 0, 3));
    prog(ad(3, 0), mk(1, 0, 7, 0));
    clear_tape();
    start_run(4);
    wait_sig(1, 10, "rstmove");
    reset_n = 1'b0; tick();
    m0 = mv_q.size(); w0 = wr_q.size();
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_en", {30'd0, tape_write_en, tape_move_en}, 0);
    chk("rstmid_state", {28'd0, tm_state}, 0);
    chk("rstmid_cnt", {16'd0, step_count}, 0);
    tick(2);
    chk("rstmid_quiet", (mv_q.size() - m0) + (wr_q.size() - w0), 0);
    reset_n = 1'b1; tick();
    clear_tape();
    start_run(3);
    tick(4);
    chk("rstclr_halted", {31'd0, halted}, 0);
    chk("rstclr_busy", {31'd0, busy}, 1);
    chk("rstclr_state", {28'd0, tm_state}, 0);
    chk("rstclr_cnt", {16'd0, step_count}, 1);
    chk("rstclr_sym", wr_q[$], 0);
    abort = 1'b1; tick(); abort = 1'b0;

    chk("no_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
